// File: rtl/line_clear_engine.sv
// Line-clear evaluation stage: captures a 21x10 grid, removes full rows bottom-up and
// returns the compacted grid and the number of rows cleared. Optional score via LINE_CLEAR_SCORE_EN.
module line_clear_engine (
    input  logic                  clk,
    input  logic                  nRst_i,
    input  logic                  start_i,
    input  logic [20:0][9:0][2:0] grid_i,
    output logic [20:0][9:0][2:0] grid_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4:0]            lines_o,
    output logic [15:0]           score_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state;
    logic [20:0][9:0][2:0] work;
    logic [4:0]            r;
    logic [4:0]            cnt;
    logic                  row_full;
    logic                  finish;

    // NOTE: combinational logic assigns a default before any conditional update so no latch is inferred.
    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (work[r][c] == 3'd0) row_full = 1'b0;
        end
    end

    assign finish = (state == SCAN) && !row_full && (r == 5'd0);
    assign busy_o = (state != IDLE);
    assign done_o = (state == DONE);

    // NOTE: the working array is reset along with the control state, since a reset
    // must discard any partially collapsed grid from an aborted pass.
    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            state   <= IDLE;
            work    <= '0;
            r       <= 5'd0;
            cnt     <= 5'd0;
            grid_o  <= '0;
            lines_o <= 5'd0;
        end else begin
            // NOTE: non-blocking assignments so every row shift reads pre-edge values.
            case (state)
                IDLE: begin
                    if (start_i) begin
                        work  <= grid_i;
                        r     <= 5'd20;
                        cnt   <= 5'd0;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (row_full) begin
                        // Everything from row r upward drops one row; row 0 refills empty.
                        for (int i = 1; i < 21; i++) begin
                            if (5'(i) <= r) work[i] <= work[i-1];
                        end
                        work[0] <= '0;
                        cnt     <= cnt + 5'd1;
                    end else if (r != 5'd0) begin
                        r <= r - 5'd1;
                    end else begin
                        grid_o  <= work;
                        lines_o <= cnt;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [15:0] award;
    logic [16:0] sum;

    always_comb begin
        case (cnt)
            5'd0:    award = 16'd0;
            5'd1:    award = 16'd40;
            5'd2:    award = 16'd100;
            5'd3:    award = 16'd300;
            default: award = 16'd1200;
        endcase
        sum = {1'b0, score_o} + {1'b0, award};
    end

    always_ff @(posedge clk or negedge nRst_i) begin
        if (!nRst_i) begin
            score_o <= 16'h0000;
        end else if (finish) begin
            score_o <= sum[16] ? 16'hFFFF : sum[15:0];
        end
    end
`else
    assign score_o = 16'h0000;
`endif

endmodule
